fir_adder_tree: RTL
===================

// Module: fir_adder_tree
// PURPOSE
//   Pipelined, back-pressurable reduction stage directly downstream of the FIR
//   multiply array. Sums TAPS signed 2*WIDTH-bit products into one sample.
//   Rounds and shifts the sum back to coefficient Q-format, then saturates it
//   to OUT_WIDTH. Output feeds the FIR output register / sample sink over valid/ready.
// PARAMETERS
//   WIDTH      16  tap/coeff width; each product is 2*WIDTH bits signed
//   TAPS       8   number of products; legal range 2..64, need not be a power of 2
//   OUT_WIDTH  16  output sample width, signed
//   SHIFT      15  right shift applied after the sum (Q15 coefficients); 1..2*WIDTH-1
// PORTS
//   clk            in   1                 rising-edge clock
//   rst_n          in   1                 asynchronous active-low reset
//   in_valid       in   1                 products_flat holds a valid product set
//   in_ready       out  1                 stage can accept products this cycle
//   products_flat  in   TAPS*2*WIDTH      product i at [2*WIDTH*(i+1)-1 -: 2*WIDTH], signed
//   out_valid      out  1                 out_sample valid
//   out_ready      in   1                 downstream accepts out_sample
//   out_sample     out  OUT_WIDTH         rounded, saturated filter output, signed
//   out_sat        out  1                 out_sample was clipped (qualified by out_valid)
// BEHAVIOUR
//   - Reset (rst_n=0, async): all pipeline valid bits, out_valid, out_sample and
//     out_sat clear to 0. in_ready reads 1 while reset is released. Data in
//     flight is discarded; no partial output is ever emitted.
//   - Sums use ACC_W = 2*WIDTH + $clog2(TAPS) bits. Every add sign-extends, so
//     no intermediate overflow is possible.
//   - Tree: LEVELS = $clog2(TAPS) register stages, each a pairwise add.
//     An odd element at a level passes through registered, unchanged (zero-padded).
//   - Final stage (registered): r = sum + (1 << (SHIFT-1)), then arithmetic
//     shift right by SHIFT (round-half-up, toward +inf on ties).
//     r > 2^(OUT_WIDTH-1)-1 -> out_sample = max positive, out_sat = 1.
//     r < -2^(OUT_WIDTH-1) -> out_sample = min negative, out_sat = 1.
//     Otherwise out_sample = r[OUT_WIDTH-1:0] and out_sat = 0.
//   - Latency: LEVELS+1 cycles from accepted input to out_valid with no stalls
//     (4 cycles at TAPS=8).
//   - Flow control: single global enable, adv = ~out_valid | out_ready.
//     in_ready = adv, combinational from out_valid/out_ready only.
//     An input transfers when in_valid & in_ready. When adv=1 every stage
//     (data and valid bit) shifts one step. When adv=0 every stage holds.
//   - Bubbles: a valid bit of 0 propagates as a bubble. Data registers may
//     update on a bubble but are never observed, because out_valid gates them.
//   - Throughput: 1 sample/cycle while out_ready=1.
//   - out_valid, out_sample and out_sat hold stable while out_valid=1 & out_ready=0.
//   - Ordering: outputs leave in input order. No sample is dropped or
//     duplicated under any out_ready pattern.
//   - Simultaneous accept at input and consume at output in one cycle is legal
//     and is the steady-state case.
//   - in_valid=1 with in_ready=0: the upstream source must hold its data.
//     The block does not sample it.
// TESTING
//   1 Directed scenarios (TAPS=8, WIDTH=16, OUT_WIDTH=16, SHIFT=15):
//     - All 8 products = 32768, out_ready=1 -> out_sample=8, out_sat=0, out_valid
//       exactly 4 cycles after accept.
//     - Product0 = 16384, others 0 -> out_sample=1.
//     - Product0 = 16383, others 0 -> out_sample=0.
//     - Product0 = -16384, others 0 -> out_sample=0 (half rounds up).
//     - All products = 32767*32767 -> out_sample=32767, out_sat=1.
//     - All products = -32768*32767 -> out_sample=-32768, out_sat=1.
//   2 Six back-to-back inputs (product0 = k<<15, k=1..6), with out_ready low for
//     3 cycles starting when the first out_valid rises -> outputs 1..6 in order,
//     none lost. out_sample stable while stalled. in_ready=0 exactly while stalled.
//   3 Odd TAPS=5, all products = 32768 -> out_sample=5 after 4 cycles
//     ($clog2(5)=3 levels + 1).
//   4 Random in_valid/out_ready streams (10k samples) vs a behavioural
//     sum/round/saturate model -> exact match, out_sat matches model.
//   5 rst_n pulsed low for 1 cycle with 3 samples in flight -> out_valid=0,
//     out_sample=0 immediately. No stale sample appears after release.
//     The next accepted input emerges after 4 cycles.

Source files
------------

// File: rtl/fir_adder_tree.sv
// fir_adder_tree
// Pipelined signed reduction of TAPS products into one filter sample.
// A binary tree of registered pairwise adds (odd leftovers pass through),
// followed by a registered round-half-up / arithmetic shift / saturate stage.
// The whole pipeline advances on one global enable so back-pressure from the
// sink freezes every stage at once and in_ready never depends on in_valid.
module fir_adder_tree #(
   parameter int WIDTH     = 16,
   parameter int TAPS      = 8,
   parameter int OUT_WIDTH = 16,
   parameter int SHIFT     = 15
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [TAPS*2*WIDTH-1:0]     products_flat,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [OUT_WIDTH-1:0] out_sample,
   output logic                        out_sat
);

   localparam int PW     = 2 * WIDTH;
   localparam int LEVELS = $clog2(TAPS);
   localparam int ACC_W  = PW + LEVELS;
   // One spare bit so adding the rounding constant can never wrap.
   localparam int RW     = ACC_W + 1;

   localparam logic signed [RW-1:0] C_HALF = RW'(64'sd1 <<< (SHIFT - 1));
   localparam logic signed [RW-1:0] C_MAX  = RW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
   localparam logic signed [RW-1:0] C_MIN  = RW'(-(64'sd1 <<< (OUT_WIDTH - 1)));
   localparam logic signed [OUT_WIDTH-1:0] O_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [OUT_WIDTH-1:0] O_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

   // Number of live elements entering tree level lvl (level 0 = raw products).
   function automatic int lvl_cnt(input int lvl);
      return (TAPS + (1 << lvl) - 1) >> lvl;
   endfunction

   logic signed [ACC_W-1:0]     w_in  [TAPS];
   logic signed [ACC_W-1:0]     w_nxt [LEVELS][TAPS];
   logic signed [ACC_W-1:0]     r_tree[LEVELS][TAPS];
   logic [LEVELS-1:0]           r_vld;
   logic                        w_adv;
   logic signed [RW-1:0]        w_rnd;
   logic signed [RW-1:0]        w_shf;
   logic signed [OUT_WIDTH-1:0] w_sample;
   logic                        w_sat;
   logic                        r_out_valid;
   logic signed [OUT_WIDTH-1:0] r_out_sample;
   logic                        r_out_sat;

   // Global advance: move whenever the output slot is empty or being drained.
   assign w_adv     = ~r_out_valid | out_ready;
   assign in_ready  = w_adv;
   assign out_valid = r_out_valid;
   assign out_sample = r_out_sample;
   assign out_sat   = r_out_sat;

   // Unpack and sign-extend every product to the accumulator width.
   always_comb begin
      for (int i = 0; i < TAPS; i++) begin
         w_in[i] = ACC_W'($signed(products_flat[PW*i +: PW]));
      end
   end

   // Next value of every tree register: pairwise sums, odd element forwarded.
   always_comb begin
      for (int l = 0; l < LEVELS; l++) begin
         for (int j = 0; j < TAPS; j++) begin
            w_nxt[l][j] = '0;
            if (l == 0) begin
               if (2 * j + 1 < TAPS) begin
                  w_nxt[l][j] = w_in[2*j] + w_in[2*j+1];
               end else if (2 * j < TAPS) begin
                  w_nxt[l][j] = w_in[2*j];
               end else begin
                  w_nxt[l][j] = '0;
               end
            end else begin
               if (2 * j + 1 < lvl_cnt(l)) begin
                  w_nxt[l][j] = r_tree[l-1][2*j] + r_tree[l-1][2*j+1];
               end else if (2 * j < lvl_cnt(l)) begin
                  w_nxt[l][j] = r_tree[l-1][2*j];
               end else begin
                  w_nxt[l][j] = '0;
               end
            end
         end
      end
   end

   // Round half up, shift back to sample scale, clip to the output range.
   always_comb begin
      w_rnd    = RW'(r_tree[LEVELS-1][0]) + C_HALF;
      w_shf    = w_rnd >>> SHIFT;
      w_sample = w_shf[OUT_WIDTH-1:0];
      w_sat    = 1'b0;
      if (w_shf > C_MAX) begin
         w_sample = O_MAX;
         w_sat    = 1'b1;
      end else if (w_shf < C_MIN) begin
         w_sample = O_MIN;
         w_sat    = 1'b1;
      end else begin
         w_sat    = 1'b0;
      end
   end

   // Tree data and valid bits: all stages shift together on advance, else hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
         for (int l = 0; l < LEVELS; l++) begin
            for (int j = 0; j < TAPS; j++) begin
               r_tree[l][j] <= '0;
            end
         end
      end else if (w_adv) begin
         r_vld[0] <= in_valid;
         for (int l = 1; l < LEVELS; l++) begin
            r_vld[l] <= r_vld[l-1];
         end
         for (int l = 0; l < LEVELS; l++) begin
            for (int j = 0; j < TAPS; j++) begin
               r_tree[l][j] <= w_nxt[l][j];
            end
         end
      end
   end

   // Output register: loads the rounded sample on advance, frozen while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_out_sample <= '0;
         r_out_sat    <= 1'b0;
      end else if (w_adv) begin
         r_out_valid  <= r_vld[LEVELS-1];
         r_out_sample <= w_sample;
         r_out_sat    <= w_sat;
      end
   end

endmodule
